// File: rtl/descriptor_input_receiver_pkg.sv
// descriptor_input_receiver_pkg: shared descriptor layout and receive FSM encodings
package descriptor_input_receiver_pkg;
    localparam int DESC_DW = 40;
    localparam int TSNTAG_MSB = 39;
    localparam int TSNTAG_LSB = 9;
    localparam int BUFID_MSB = 8;
    localparam int BUFID_LSB = 0;
    localparam logic [0:0] RX_IDLE = 1'b0;
    localparam logic [0:0] RX_ACK = 1'b1;
endpackage

// File: rtl/descriptor_input_receiver_fifo.sv
// desc_sync_fifo: first-word-fall-through synchronous FIFO with occupancy, full and empty
module desc_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW = 4,
    parameter int DW = 40
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_wr,
    input  logic [DW-1:0] iv_data,
    input  logic          i_rd,
    output logic [DW-1:0] ov_head,
    output logic [AW:0]   ov_usedw,
    output logic          o_full,
    output logic          o_empty
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic wr_en, rd_en;
    assign o_full = ov_usedw == (AW+1)'(DEPTH);
    assign o_empty = ov_usedw == '0;
    assign wr_en = i_wr & ~o_full;
    assign rd_en = i_rd & ~o_empty;
    assign ov_head = o_empty ? '0 : mem[rptr];
    // pointers wrap naturally at DEPTH; a simultaneous write and pop leaves occupancy unchanged
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr <= '0;
            rptr <= '0;
            ov_usedw <= '0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (rd_en) rptr <= rptr + 1'b1;
            ov_usedw <= ov_usedw + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
        end
    end
    // storage is not reset; empty gating hides stale contents
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wptr] <= iv_data;
    end
endmodule

// File: rtl/descriptor_input_receiver.sv
// descriptor_input_receiver: write/ack descriptor capture into a FWFT queue with statistics
module descriptor_input_receiver
    import descriptor_input_receiver_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW = 4,
    parameter int DW = DESC_DW,
    parameter int CW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [DW-1:0] iv_descriptor,
    input  logic          i_descriptor_wr,
    output logic          o_descriptor_ack,
    output logic [DW-1:0] ov_head_descriptor,
    output logic          o_fifo_empty,
    input  logic          i_head_rd,
    output logic [AW:0]   ov_fifo_usedw,
    output logic          o_fifo_full,
    output logic [CW-1:0] ov_rx_cnt,
    output logic [CW-1:0] ov_pop_cnt
);
    logic [0:0] state;
    logic fifo_wr, pop;
    assign fifo_wr = (state == RX_IDLE) & i_descriptor_wr & ~o_fifo_full;
    assign pop = i_head_rd & ~o_fifo_empty;
    assign o_descriptor_ack = state == RX_ACK;

    desc_sync_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
        .i_clk(i_clk),
        .i_rst(i_rst),
        .i_wr(fifo_wr),
        .iv_data(iv_descriptor),
        .i_rd(i_head_rd),
        .ov_head(ov_head_descriptor),
        .ov_usedw(ov_fifo_usedw),
        .o_full(o_fifo_full),
        .o_empty(o_fifo_empty)
    );

    // accept in idle then spend exactly one cycle acking while the sender's stale wr is ignored
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= RX_IDLE;
            ov_rx_cnt <= '0;
            ov_pop_cnt <= '0;
        end else begin
            state <= fifo_wr ? RX_ACK : RX_IDLE;
            ov_rx_cnt <= ov_rx_cnt + {{(CW-1){1'b0}}, fifo_wr};
            ov_pop_cnt <= ov_pop_cnt + {{(CW-1){1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_descriptor_input_receiver.sv
// tb_descriptor_input_receiver: directed checks of handshake, FIFO order, full stall and reset
module tb_descriptor_input_receiver;
    logic        clk = 0;
    logic        rst;
    logic [39:0] desc;
    logic        wr;
    logic        ack;
    logic [39:0] head;
    logic        empty;
    logic        rd;
    logic [4:0]  usedw;
    logic        full;
    logic [15:0] rx_cnt;
    logic [15:0] pop_cnt;
    int checks = 0;
    int failures = 0;
    int acks;

    always #5 clk = ~clk;

    descriptor_input_receiver dut (
        .i_clk(clk),
        .i_rst(rst),
        .iv_descriptor(desc),
        .i_descriptor_wr(wr),
        .o_descriptor_ack(ack),
        .ov_head_descriptor(head),
        .o_fifo_empty(empty),
        .i_head_rd(rd),
        .ov_fifo_usedw(usedw),
        .o_fifo_full(full),
        .ov_rx_cnt(rx_cnt),
        .ov_pop_cnt(pop_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [39:0] d);
        int n;
        desc = d;
        wr = 1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!ack && n < 20);
        check("offer_ack", {63'd0, ack}, 64'd1);
        tick();
        wr = 0;
        tick();
    endtask

    initial begin
        rst = 1; wr = 0; rd = 0; desc = '0;
        tick(); tick();
        rst = 0;
        check("rst_ack", {63'd0, ack}, 0);
        check("rst_empty", {63'd0, empty}, 1);
        check("rst_full", {63'd0, full}, 0);
        check("rst_usedw", 64'(usedw), 0);
        check("rst_rx", 64'(rx_cnt), 0);
        check("rst_pop", 64'(pop_cnt), 0);
        check("rst_head", 64'(head), 0);

        rd = 1;
        tick(); tick(); tick();
        rd = 0;
        check("rdempty_usedw", 64'(usedw), 0);
        check("rdempty_pop", 64'(pop_cnt), 0);
        check("rdempty_empty", {63'd0, empty}, 1);

        desc = 40'h12_3456_789A; wr = 1;
        tick();
        check("single_ack", {63'd0, ack}, 1);
        check("single_head", 64'(head), 64'h12_3456_789A);
        check("single_empty", {63'd0, empty}, 0);
        check("single_usedw", 64'(usedw), 1);
        check("single_rx", 64'(rx_cnt), 1);
        tick();
        wr = 0;
        check("held_ack", {63'd0, ack}, 0);
        check("held_usedw", 64'(usedw), 1);
        check("held_rx", 64'(rx_cnt), 1);
        tick();
        check("held_ack2", {63'd0, ack}, 0);
        check("held_usedw2", 64'(usedw), 1);
        rd = 1;
        tick();
        rd = 0;
        check("pop1_empty", {63'd0, empty}, 1);
        check("pop1_usedw", 64'(usedw), 0);
        check("pop1_cnt", 64'(pop_cnt), 1);

        for (int i = 0; i < 16; i++) offer(40'(i));
        check("b2b_full", {63'd0, full}, 1);
        check("b2b_usedw", 64'(usedw), 16);
        check("b2b_rx", 64'(rx_cnt), 17);
        check("b2b_head", 64'(head), 0);
        desc = 40'd16; wr = 1;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            acks += int'(ack);
        end
        check("full_noack", 64'(acks), 0);
        check("full_rx", 64'(rx_cnt), 17);
        rd = 1;
        tick();
        rd = 0;
        check("unfull_usedw", 64'(usedw), 15);
        check("unfull_ack", {63'd0, ack}, 0);
        check("unfull_head", 64'(head), 1);
        tick();
        check("late_ack", {63'd0, ack}, 1);
        check("late_usedw", 64'(usedw), 16);
        check("late_rx", 64'(rx_cnt), 18);
        tick();
        wr = 0;
        tick();

        for (int i = 1; i <= 8; i++) begin
            check("drain8_head", 64'(head), 64'(i));
            rd = 1;
            tick();
        end
        rd = 0;
        check("mid_usedw", 64'(usedw), 8);
        check("mid_pop", 64'(pop_cnt), 10);
        check("conc_head", 64'(head), 9);
        desc = 40'd17; wr = 1; rd = 1;
        tick();
        rd = 0;
        check("conc_ack", {63'd0, ack}, 1);
        check("conc_usedw", 64'(usedw), 8);
        check("conc_rx", 64'(rx_cnt), 19);
        check("conc_pop", 64'(pop_cnt), 11);
        tick();
        wr = 0;
        tick();
        for (int i = 18; i < 24; i++) offer(40'(i));
        check("refill_usedw", 64'(usedw), 14);
        check("refill_rx", 64'(rx_cnt), 25);
        for (int i = 10; i < 24; i++) begin
            check("wrap_head", 64'(head), 64'(i));
            rd = 1;
            tick();
        end
        rd = 0;
        check("wrap_empty", {63'd0, empty}, 1);
        check("wrap_usedw", 64'(usedw), 0);
        check("wrap_pop", 64'(pop_cnt), 25);

        rst = 1; wr = 1; desc = 40'hAB_CDEF_0123;
        tick();
        check("rstmid_ack", {63'd0, ack}, 0);
        check("rstmid_usedw", 64'(usedw), 0);
        check("rstmid_rx", 64'(rx_cnt), 0);
        check("rstmid_pop", 64'(pop_cnt), 0);
        check("rstmid_empty", {63'd0, empty}, 1);
        rst = 0;
        tick();
        check("reoffer_ack", {63'd0, ack}, 1);
        check("reoffer_head", 64'(head), 64'hAB_CDEF_0123);
        check("reoffer_usedw", 64'(usedw), 1);
        check("reoffer_rx", 64'(rx_cnt), 1);
        tick();
        wr = 0;
        tick();
        check("reoffer_once", 64'(usedw), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
